key_cmd_decoder: RTL

KEY_CMD_DECODER -- requirements
Module: key_cmd_decoder

---
 rtl/tank_pkg.sv | 57 +++++
 rtl/key_player_ctrl.sv | 60 ++++++
 rtl/key_cmd_decoder.sv | 107 ++++++++++
 3 files changed

// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared types, keycodes and helpers for the keyboard command decoder
package tank_pkg;

  // Move command driven to the game logic; 5..7 are never produced
  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  // Report handshake states
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_DECODE = 1'b1
  } fsm_t;

  localparam int SLOT_W    = 8;
  localparam int NUM_SLOTS = 4;
  localparam int NUM_KEYS  = 10;

  // USB HID usage codes for the mapped keys
  localparam logic [SLOT_W-1:0] KEY_P1_UP    = 8'h1A;  // W
  localparam logic [SLOT_W-1:0] KEY_P1_DOWN  = 8'h16;  // S
  localparam logic [SLOT_W-1:0] KEY_P1_LEFT  = 8'h04;  // A
  localparam logic [SLOT_W-1:0] KEY_P1_RIGHT = 8'h07;  // D
  localparam logic [SLOT_W-1:0] KEY_P1_FIRE  = 8'h14;  // Q
  localparam logic [SLOT_W-1:0] KEY_P2_UP    = 8'h52;  // Up arrow
  localparam logic [SLOT_W-1:0] KEY_P2_DOWN  = 8'h51;  // Down arrow
  localparam logic [SLOT_W-1:0] KEY_P2_LEFT  = 8'h50;  // Left arrow
  localparam logic [SLOT_W-1:0] KEY_P2_RIGHT = 8'h4F;  // Right arrow
  localparam logic [SLOT_W-1:0] KEY_P2_FIRE  = 8'h10;  // M

  // Bit positions inside the held-key vector
  localparam int HK_P1_UP    = 0;
  localparam int HK_P1_DOWN  = 1;
  localparam int HK_P1_LEFT  = 2;
  localparam int HK_P1_RIGHT = 3;
  localparam int HK_P1_FIRE  = 4;
  localparam int HK_P2_UP    = 5;
  localparam int HK_P2_DOWN  = 6;
  localparam int HK_P2_LEFT  = 7;
  localparam int HK_P2_RIGHT = 8;
  localparam int HK_P2_FIRE  = 9;

  // Fixed direction priority: UP > DOWN > LEFT > RIGHT
  function automatic dir_t pick_dir(input logic up, input logic down,
                                    input logic left, input logic right);
    if (up)         return DIR_UP;
    else if (down)  return DIR_DOWN;
    else if (left)  return DIR_LEFT;
    else if (right) return DIR_RIGHT;
    else            return DIR_NONE;
  endfunction

endpackage

// File: rtl/key_player_ctrl.sv
// rtl/key_player_ctrl.sv - per-player direction priority, fire edge and cooldown (KEY_AUTO_FIRE_EN enables auto-fire)
module key_player_ctrl
  import tank_pkg::*;
#(
  parameter int FIRE_COOLDOWN = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_fire,
  output logic [2:0] o_dir,
  output logic       o_fire
);

  localparam logic [7:0] COOLDOWN_LD = 8'(FIRE_COOLDOWN);

  dir_t       r_dir;
  logic       r_fire;
  logic       r_prev_fire;
  logic [7:0] r_cd;

  logic [7:0] w_cd_dec;
  logic       w_fire_go;

  // Cooldown as it stands after this tick's decrement; fire is judged on that value
  always_comb begin
    w_cd_dec = (r_cd != 8'd0) ? (r_cd - 8'd1) : 8'd0;
`ifdef KEY_AUTO_FIRE_EN
    w_fire_go = i_fire && (w_cd_dec == 8'd0);
`else
    w_fire_go = i_fire && !r_prev_fire && (w_cd_dec == 8'd0);
`endif
  end

  // Frame-rate update of direction, fire pulse, press history and cooldown
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_dir       <= DIR_NONE;
      r_fire      <= 1'b0;
      r_prev_fire <= 1'b0;
      r_cd        <= 8'd0;
    end else begin
      r_fire <= 1'b0;
      if (frame_tick) begin
        r_dir       <= pick_dir(i_up, i_down, i_left, i_right);
        r_prev_fire <= i_fire;
        r_fire      <= w_fire_go;
        r_cd        <= w_fire_go ? COOLDOWN_LD : w_cd_dec;
      end
    end
  end

  assign o_dir  = r_dir;
  assign o_fire = r_fire;

endmodule

// File: rtl/key_cmd_decoder.sv
// rtl/key_cmd_decoder.sv - USB keyboard report decoder for two players (KEY_AUTO_FIRE_EN enables auto-fire)
module key_cmd_decoder
  import tank_pkg::*;
#(
  parameter int FIRE_COOLDOWN = 16
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        kc_valid,
  input  logic [NUM_SLOTS*SLOT_W-1:0] kc_in,
  output logic                        kc_ready,
  input  logic                        frame_tick,
  output logic [2:0]                  p1_dir,
  output logic                        p1_fire,
  output logic [2:0]                  p2_dir,
  output logic                        p2_fire
);

  fsm_t                        r_state;
  fsm_t                        w_state_nxt;
  logic                        w_accept;
  logic                        w_decode;
  logic [NUM_SLOTS*SLOT_W-1:0] r_kc;
  logic [NUM_KEYS-1:0]         r_held;
  logic [NUM_KEYS-1:0]         w_held_nxt;

  // Handshake state register
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: accept in IDLE, spend exactly one cycle in DECODE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (kc_valid) w_state_nxt = ST_DECODE;
      ST_DECODE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    kc_ready = (r_state == ST_IDLE);
    w_decode = (r_state == ST_DECODE);
    w_accept = kc_ready && kc_valid;
  end

  // Report capture and held-key replacement; a tick in the same cycle still sees the old vector
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_kc   <= '0;
      r_held <= '0;
    end else begin
      if (w_accept) r_kc <= kc_in;
      if (w_decode) r_held <= w_held_nxt;
    end
  end

  // A key is held if its code appears in any slot; empty and unknown codes fall through
  always_comb begin
    w_held_nxt = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      case (r_kc[s*SLOT_W +: SLOT_W])
        KEY_P1_UP:    w_held_nxt[HK_P1_UP]    = 1'b1;
        KEY_P1_DOWN:  w_held_nxt[HK_P1_DOWN]  = 1'b1;
        KEY_P1_LEFT:  w_held_nxt[HK_P1_LEFT]  = 1'b1;
        KEY_P1_RIGHT: w_held_nxt[HK_P1_RIGHT] = 1'b1;
        KEY_P1_FIRE:  w_held_nxt[HK_P1_FIRE]  = 1'b1;
        KEY_P2_UP:    w_held_nxt[HK_P2_UP]    = 1'b1;
        KEY_P2_DOWN:  w_held_nxt[HK_P2_DOWN]  = 1'b1;
        KEY_P2_LEFT:  w_held_nxt[HK_P2_LEFT]  = 1'b1;
        KEY_P2_RIGHT: w_held_nxt[HK_P2_RIGHT] = 1'b1;
        KEY_P2_FIRE:  w_held_nxt[HK_P2_FIRE]  = 1'b1;
        default: ;
      endcase
    end
  end

  key_player_ctrl #(.FIRE_COOLDOWN(FIRE_COOLDOWN)) u_p1 (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .i_up       (r_held[HK_P1_UP]),
    .i_down     (r_held[HK_P1_DOWN]),
    .i_left     (r_held[HK_P1_LEFT]),
    .i_right    (r_held[HK_P1_RIGHT]),
    .i_fire     (r_held[HK_P1_FIRE]),
    .o_dir      (p1_dir),
    .o_fire     (p1_fire)
  );

  key_player_ctrl #(.FIRE_COOLDOWN(FIRE_COOLDOWN)) u_p2 (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .i_up       (r_held[HK_P2_UP]),
    .i_down     (r_held[HK_P2_DOWN]),
    .i_left     (r_held[HK_P2_LEFT]),
    .i_right    (r_held[HK_P2_RIGHT]),
    .i_fire     (r_held[HK_P2_FIRE]),
    .o_dir      (p2_dir),
    .o_fire     (p2_fire)
  );

endmodule
